// File: rtl/ir_pkg.sv
// Shared definitions for the instruction queue and its decoder: default field
// widths, the operand-width helper and the opcode encoding.
package ir_pkg;

  localparam int IR_INSTR_W  = 8;
  localparam int IR_OPCODE_W = 3;

  // Operand field is whatever remains below the opcode.
  function automatic int operand_w(input int instr_w, input int opcode_w);
    return instr_w - opcode_w;
  endfunction

  typedef enum logic [IR_OPCODE_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_STOR = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_JMP  = 3'd6,
    OP_BRZ  = 3'd7
  } ir_opcode_e;

endpackage

// File: rtl/ir_queue_mem.sv
// DEPTH x INSTR_W register array for the instruction queue: one synchronous
// write port and one asynchronous read port.
module ir_queue_mem #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers and count,
  // so unwritten entries are never presented at the outputs.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ir_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode, head word split into
// opcode/operand. Define IR_QUEUE_BYPASS_EN to forward words through an empty queue.
module ir_queue
  import ir_pkg::*;
#(
  parameter int INSTR_W  = IR_INSTR_W,
  parameter int OPCODE_W = IR_OPCODE_W,
  parameter int DEPTH    = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [INSTR_W-1:0]                          in_instr,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [OPCODE_W-1:0]                         out_opcode,
  output logic [operand_w(INSTR_W, OPCODE_W)-1:0]     out_operand,
  output logic [$clog2(DEPTH+1)-1:0]                  count
);

  localparam int OPERAND_W = operand_w(INSTR_W, OPCODE_W);
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = $clog2(DEPTH+1);

  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_we;
  logic               w_head_valid;
  logic [INSTR_W-1:0] w_rdata;
  logic [INSTR_W-1:0] w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  // Depends on registered count only, so fetch never sees out_ready combinationally.
  assign in_ready = !w_full;
  assign w_pop    = !w_empty && out_ready;

`ifdef IR_QUEUE_BYPASS_EN
  logic w_bypass_sel;

  assign w_bypass_sel = w_empty && !flush && in_valid;
  assign w_push       = in_valid && in_ready && !(w_bypass_sel && out_ready);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_head_valid = 1'b0;
    w_head       = '0;
    if (!w_empty) begin
      w_head_valid = 1'b1;
      w_head       = w_rdata;
    end else if (w_bypass_sel) begin
      w_head_valid = 1'b1;
      w_head       = in_instr;
    end
  end
`else
  assign w_push = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_head_valid = 1'b0;
    w_head       = '0;
    if (!w_empty) begin
      w_head_valid = 1'b1;
      w_head       = w_rdata;
    end
  end
`endif

  assign w_we = w_push && !flush && !rst;

  ir_queue_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .AW      (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (in_instr),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid   = w_head_valid;
  assign out_opcode  = w_head[INSTR_W-1 -: OPCODE_W];
  assign out_operand = w_head[OPERAND_W-1:0];
  assign count       = r_count;

endmodule
